// File: rtl/seq_link_pkg.sv
// Shared types and constants for the serial sequence link (pattern transmitter and detector side).
package seq_link_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      GAP   = 2'd2,
      DONE  = 2'd3
   } tx_state_t;

   localparam logic IDLE_LVL_DEFAULT = 1'b0;

endpackage

// File: rtl/serial_pattern_tx_shift.sv
// pat_shift_reg: latches the pattern, shifts it out MSB-first and tracks the bit index of the frame.
// With PATTX_PARITY_EN defined the frame gains a trailing even-parity bit.
module pat_shift_reg #(
   parameter int PAT_W = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic             reload,
   input  logic             shift,
   input  logic [PAT_W-1:0] pattern_in,
   output logic             bit_out,
   output logic             first_bit,
   output logic             last_bit
);

   localparam int IDX_W = $clog2(PAT_W + 1);

   logic [PAT_W-1:0] pat_lat;
   logic [PAT_W-1:0] sr;
   logic [IDX_W-1:0] idx;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pat_lat <= '0;
         sr      <= '0;
         idx     <= '0;
      end else if (load) begin
         pat_lat <= pattern_in;
         sr      <= pattern_in;
         idx     <= '0;
      end else if (reload) begin
         sr      <= pat_lat;
         idx     <= '0;
      end else if (shift) begin
         sr      <= {sr[PAT_W-2:0], 1'b0};
         idx     <= idx + IDX_W'(1);
      end
   end

   assign first_bit = (idx == '0);

`ifdef PATTX_PARITY_EN
   // index PAT_W is the parity slot that follows the last data bit
   assign bit_out  = (idx == IDX_W'(PAT_W)) ? ^pat_lat : sr[PAT_W-1];
   assign last_bit = (idx == IDX_W'(PAT_W));
`else
   assign bit_out  = sr[PAT_W-1];
   assign last_bit = (idx == IDX_W'(PAT_W - 1));
`endif

endmodule

// File: rtl/serial_pattern_tx.sv
// Serial pattern transmitter: repeats a latched pattern MSB-first with idle gaps, then pulses done.
// Optional PATTX_PARITY_EN appends an even-parity bit to every frame.
//
// state | meaning
// IDLE  | waiting for start; ready asserted once the previous done has cleared
// SHIFT | one frame bit per cycle (data bits, then parity when enabled)
// GAP   | GAP_CYC idle-level cycles between repetitions
// DONE  | single cycle after the last frame; produces the done pulse
module serial_pattern_tx
   import seq_link_pkg::*;
#(
   parameter int   PAT_W    = 4,
   parameter int   CNT_W    = 4,
   parameter int   GAP_CYC  = 2,
   parameter logic IDLE_LVL = IDLE_LVL_DEFAULT
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [PAT_W-1:0] pattern_in,
   input  logic [CNT_W-1:0] repeat_cnt,
   output logic             ready,
   output logic             out,
   output logic             out_valid,
   output logic             frame_start,
   output logic             done
);

   localparam int GAP_W = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;

   tx_state_t        state, state_nxt;
   logic [CNT_W-1:0] reps_left;
   logic [GAP_W-1:0] gap_cnt;
   logic             accept;
   logic             sr_load, sr_reload, sr_shift;
   logic             bit_out, first_bit, last_bit;
   logic             ready_q, out_q, out_valid_q, frame_start_q, done_q;

   // ready_q can only be high while the FSM sits in IDLE, so it alone qualifies start
   assign accept = start & ready_q;

   pat_shift_reg #(.PAT_W(PAT_W)) u_shift (
      .clk        (clk),
      .reset      (reset),
      .load       (sr_load),
      .reload     (sr_reload),
      .shift      (sr_shift),
      .pattern_in (pattern_in),
      .bit_out    (bit_out),
      .first_bit  (first_bit),
      .last_bit   (last_bit)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      sr_load   = 1'b0;
      sr_reload = 1'b0;
      sr_shift  = 1'b0;
      case (state)
         IDLE: begin
            if (accept) begin
               state_nxt = SHIFT;
               sr_load   = 1'b1;
            end
         end
         SHIFT: begin
            if (last_bit) begin
               sr_reload = 1'b1;
               if (reps_left > CNT_W'(1)) state_nxt = (GAP_CYC == 0) ? SHIFT : GAP;
               else                       state_nxt = DONE;
            end else begin
               sr_shift = 1'b1;
            end
         end
         GAP: begin
            if (gap_cnt == '0) state_nxt = SHIFT;
         end
         DONE: state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         reps_left <= '0;
         gap_cnt   <= '0;
      end else begin
         if (accept)
            reps_left <= (repeat_cnt == '0) ? CNT_W'(1) : repeat_cnt;
         else if (state == SHIFT && last_bit && reps_left > CNT_W'(1))
            reps_left <= reps_left - CNT_W'(1);

         if (state == SHIFT && last_bit)
            gap_cnt <= (GAP_CYC > 0) ? GAP_W'(GAP_CYC - 1) : '0;
         else if (state == GAP && gap_cnt != '0)
            gap_cnt <= gap_cnt - GAP_W'(1);
      end
   end

   // outputs are registered from the current state, so they trail it by one cycle
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ready_q       <= 1'b1;
         out_q         <= IDLE_LVL;
         out_valid_q   <= 1'b0;
         frame_start_q <= 1'b0;
         done_q        <= 1'b0;
      end else begin
         ready_q       <= (state == IDLE) && !accept;
         out_q         <= (state == SHIFT) ? bit_out : IDLE_LVL;
         out_valid_q   <= (state == SHIFT);
         frame_start_q <= (state == SHIFT) && first_bit;
         done_q        <= (state == DONE);
      end
   end

   assign ready       = ready_q;
   assign out         = out_q;
   assign out_valid   = out_valid_q;
   assign frame_start = frame_start_q;
   assign done        = done_q;

endmodule
